clock_ratio_meter: RTL and testbench
====================================

// Module: clock_ratio_meter
// PURPOSE
//   Measuring end of the clock-divider path. Recovers the divide ratio of a
//   slow clock derived from clk_in by counting clk_in cycles between rising
//   edges; also reports high time and a lock flag. Used to check divider
//   outputs in-system and to feed ratio readback to control logic.
// PARAMETERS
//   WIDTH        32     width of counters and measured outputs
//   SYNC_STAGES  2      flops in sig_in synchronizer (>=1)
//   LOCK_COUNT   4      consecutive identical periods required to lock (>=1)
//   TIMEOUT      2^24   clk_in cycles without a rising edge before timeout
// PORTS
//   clk_in      in   1      measurement clock; all logic on posedge
//   reset       in   1      asynchronous, active-low reset
//   sig_in      in   1      divided clock under measurement
//   ratio_out   out  WIDTH  last measured period, in clk_in cycles
//   high_out    out  WIDTH  last measured high time, in clk_in cycles
//   meas_valid  out  1      1-cycle pulse: ratio_out/high_out updated
//   locked      out  1      LOCK_COUNT consecutive equal periods seen
//   timeout     out  1      1-cycle pulse: no rising edge within TIMEOUT
// BEHAVIOUR
//   Reset (reset==0, async): all outputs, counters, sync flops -> 0;
//     state -> IDLE.
//   Edge detect: s = last synchronizer stage, p = s delayed 1 cycle.
//     rise = s & ~p; fall = ~s & p.
//     Detection latency from sig_in = SYNC_STAGES+1 cycles (constant).
//   per_cnt: set to 0 on rise; otherwise +1, saturating at 2^WIDTH-1.
//   States:
//     IDLE:    wait for a rise. Rise -> MEAS, per_cnt=0, no meas_valid.
//              fall is ignored.
//     MEAS:    on fall: hi_cap <= per_cnt+1 (rise-to-fall cycles).
//              on rise: ratio_out <= per_cnt+1; high_out <= hi_cap;
//              meas_valid=1 next cycle; per_cnt=0.
//              per_cnt == TIMEOUT-1 with no rise -> timeout pulse,
//              locked=0, state=IDLE; ratio_out/high_out hold.
//   Lock: match_cnt counts consecutive periods equal to the previous one,
//     saturating at LOCK_COUNT. A mismatch sets match_cnt=1.
//     locked = (match_cnt >= LOCK_COUNT), updated with meas_valid.
//     The first period after IDLE counts as match_cnt=1.
//   Boundaries:
//     Rise and timeout in the same cycle: rise wins (measurement, no timeout).
//     Minimum measurable period is 2 (sig toggling every cycle).
//     Constant sig_in (ratio 0/1 divider) -> timeout, never valid.
//     If no fall is seen since the last rise, high_out reports the previous
//       hi_cap value.
//     Width: per_cnt+1 truncated to WIDTH bits; with TIMEOUT < 2^WIDTH this
//       never wraps.
//     Reset mid-measurement discards any partial count; the first rise after
//       release only arms (no meas_valid).
// TESTING
//   1 sig_in from a ratio-4 divider -> meas_valid every 4 cycles,
//     ratio_out=4, high_out=2; locked=1 at the 4th meas_valid.
//   2 ratio 10 -> ratio_out=10, high_out=5. Switch to ratio 6 mid-stream ->
//     locked drops on the first period of 6; relocks after 4 periods of 6.
//   3 sig_in toggling every cycle -> ratio_out=2, high_out=1.
//   4 sig_in held low after locking, TIMEOUT=64 -> timeout pulses once
//     64 cycles after the last per_cnt reset; locked=0; ratio_out holds;
//     the next rise only re-arms.
//   5 reset pulled low mid-period -> all outputs 0 immediately; first
//     meas_valid at the 2nd rise after release.
//   6 rise coinciding with per_cnt==TIMEOUT-1 -> meas_valid,
//     ratio_out=TIMEOUT, no timeout.

Source files
------------

// File: rtl/clock_ratio_meter.sv
// Recovers the divide ratio, high time and lock state of a divided clock by counting clk_in cycles.
// Latency: sig_in edge to meas_valid is SYNC_STAGES+2 cycles; there is no backpressure, and each result is a 1-cycle pulse.
module clock_ratio_meter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 1 << 24
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] ratio_out,
  output logic [WIDTH-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] TMO_LAST = WIDTH'(TIMEOUT - 1);
  localparam logic [MW-1:0]    LOCK_SAT = MW'(LOCK_COUNT);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [WIDTH-1:0]       r_per_cnt;
  logic [WIDTH-1:0]       r_hi_cap;
  logic [MW-1:0]          r_match;

  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic [WIDTH-1:0]       w_per_inc;
  logic [MW-1:0]          w_match_next;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s & ~r_prev;
  assign w_fall    = ~w_s & r_prev;
  assign w_per_inc = r_per_cnt + 1'b1;

  // r_match==0 marks the first period after arming; it always starts a fresh run.
  always_comb begin
    w_match_next = MW'(1);
    if ((r_match != '0) && (w_per_inc == ratio_out)) begin
      w_match_next = (r_match >= LOCK_SAT) ? LOCK_SAT : r_match + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_sync     <= '0;
      r_prev     <= 1'b0;
      r_per_cnt  <= '0;
      r_hi_cap   <= '0;
      r_match    <= '0;
      ratio_out  <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      r_sync[0] <= sig_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev     <= w_s;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;

      if (w_rise) begin
        r_per_cnt <= '0;
      end else if (r_per_cnt != '1) begin
        r_per_cnt <= w_per_inc;
      end

      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= MEAS;
          end
        end
        MEAS: begin
          if (w_fall) begin
            r_hi_cap <= w_per_inc;
          end
          // A rise on the timeout cycle still completes the measurement.
          if (w_rise) begin
            ratio_out  <= w_per_inc;
            high_out   <= r_hi_cap;
            meas_valid <= 1'b1;
            r_match    <= w_match_next;
            locked     <= (w_match_next >= LOCK_SAT);
          end else if (r_per_cnt == TMO_LAST) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
            r_match <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Bench for clock_ratio_meter: the bench drives sig_in as a divider with chosen high/low times.
// A scoreboard queue holds the expected measurement for each completed period and is checked on meas_valid.
module tb_clock_ratio_meter;
  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int LOCKN = 4;
  localparam int TMO   = 64;

  typedef struct {
    logic [31:0] ratio;
    logic [31:0] high;
    logic        lock;
  } exp_t;

  logic             clk_in = 1'b0;
  logic             reset  = 1'b1;
  logic             sig_in = 1'b0;
  logic [WIDTH-1:0] ratio_out;
  logic [WIDTH-1:0] high_out;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   mv_count = 0;
  int   tmo_count = 0;
  int   tmo_cyc = 0;
  int   cyc = 0;
  int   last_rise_cyc = 0;
  bit   m_armed = 1'b0;
  int   m_cur_n = 0;
  int   m_cur_h = 0;
  int   m_last = 0;
  int   m_match = 0;

  clock_ratio_meter #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .LOCK_COUNT(LOCKN), .TIMEOUT(TMO)
  ) dut (
    .clk_in(clk_in), .reset(reset), .sig_in(sig_in),
    .ratio_out(ratio_out), .high_out(high_out), .meas_valid(meas_valid),
    .locked(locked), .timeout(timeout)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (timeout === 1'b1) begin
      tmo_count = tmo_count + 1;
      tmo_cyc = cyc;
    end
    if (reset === 1'b1 && meas_valid === 1'b1) begin
      mv_count = mv_count + 1;
      n_vec = n_vec + 1;
      if (exp_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_valid: ratio=%0d high=%0d locked=%0b, none expected", ratio_out, high_out, locked);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ratio_out !== e.ratio || high_out !== e.high || locked !== e.lock) begin
          n_err = n_err + 1;
          $display("FAIL meas: got ratio=%0d high=%0d locked=%0b, expected ratio=%0d high=%0d locked=%0b",
                   ratio_out, high_out, locked, e.ratio, e.high, e.lock);
        end
      end
    end
  end

  // One divider period: rise, h cycles high, l cycles low.
  task automatic drive_period(input int h, input int l);
    exp_t e;
    @(posedge clk_in);
    #1;
    if (m_armed) begin
      if (m_match != 0 && m_cur_n == m_last) m_match = (m_match >= LOCKN) ? LOCKN : m_match + 1;
      else m_match = 1;
      m_last = m_cur_n;
      e.ratio = m_cur_n;
      e.high  = m_cur_h;
      e.lock  = (m_match >= LOCKN);
      exp_q.push_back(e);
    end
    m_armed = 1'b1;
    m_cur_n = h + l;
    m_cur_h = h;
    sig_in = 1'b1;
    last_rise_cyc = cyc;
    repeat (h) @(posedge clk_in);
    #1 sig_in = 1'b0;
    repeat (l - 1) @(posedge clk_in);
  endtask

  task automatic hold_low(input int n);
    repeat (n) @(posedge clk_in);
    m_cur_n = m_cur_n + n;
  endtask

  task automatic check_drained(input string name);
    #1;
    n_vec = n_vec + 1;
    if (exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL %s_drained: %0d measurements outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    n_vec = n_vec + 1;
    if ({ratio_out, high_out, meas_valid, locked, timeout} !== '0) begin
      n_err = n_err + 1;
      $display("FAIL reset_outputs: ratio=%0d high=%0d mv=%0b lk=%0b to=%0b, expected all 0",
               ratio_out, high_out, meas_valid, locked, timeout);
    end
    #2 reset = 1'b1;
  endtask

  task automatic test_ratio4();
    for (int i = 0; i < 8; i++) drive_period(2, 2);
    hold_low(2);
    check_drained("ratio4");
    n_vec = n_vec + 1;
    if (ratio_out !== 32'd4 || high_out !== 32'd2 || locked !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL ratio4_final: ratio=%0d high=%0d locked=%0b, expected 4 2 1", ratio_out, high_out, locked);
    end
  endtask

  task automatic test_ratio_switch();
    for (int i = 0; i < 6; i++) drive_period(5, 5);
    #1;
    n_vec = n_vec + 1;
    if (ratio_out !== 32'd10 || high_out !== 32'd5 || locked !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL ratio10: ratio=%0d high=%0d locked=%0b, expected 10 5 1", ratio_out, high_out, locked);
    end
    drive_period(3, 3);
    drive_period(3, 3);
    #1;
    n_vec = n_vec + 1;
    if (ratio_out !== 32'd6 || locked !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL switch6_unlock: ratio=%0d locked=%0b, expected 6 0", ratio_out, locked);
    end
    drive_period(3, 3);
    drive_period(3, 3);
    #1;
    n_vec = n_vec + 1;
    if (locked !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL switch6_early_lock: locked=%0b after 3 periods of 6, expected 0", locked);
    end
    drive_period(3, 3);
    #1;
    n_vec = n_vec + 1;
    if (locked !== 1'b1 || high_out !== 32'd3) begin
      n_err = n_err + 1;
      $display("FAIL switch6_relock: locked=%0b high=%0d, expected 1 3", locked, high_out);
    end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 6; i++) drive_period(1, 1);
    hold_low(4);
    check_drained("toggle");
    n_vec = n_vec + 1;
    if (ratio_out !== 32'd2 || high_out !== 32'd1) begin
      n_err = n_err + 1;
      $display("FAIL toggle: ratio=%0d high=%0d, expected 2 1", ratio_out, high_out);
    end
  endtask

  task automatic test_timeout();
    int t0;
    for (int i = 0; i < 6; i++) drive_period(2, 2);
    hold_low(2);
    t0 = tmo_count;
    repeat (120) @(posedge clk_in);
    #1;
    m_armed = 1'b0;
    m_match = 0;
    n_vec = n_vec + 1;
    if (tmo_count - t0 != 1) begin
      n_err = n_err + 1;
      $display("FAIL timeout_pulses: saw %0d timeout cycles, expected 1", tmo_count - t0);
    end
    n_vec = n_vec + 1;
    if (tmo_cyc - last_rise_cyc != SYNC + 1 + TMO) begin
      n_err = n_err + 1;
      $display("FAIL timeout_time: %0d cycles after rise, expected %0d", tmo_cyc - last_rise_cyc, SYNC + 1 + TMO);
    end
    n_vec = n_vec + 1;
    if (locked !== 1'b0 || ratio_out !== 32'd4 || high_out !== 32'd2) begin
      n_err = n_err + 1;
      $display("FAIL timeout_state: locked=%0b ratio=%0d high=%0d, expected 0 4 2", locked, ratio_out, high_out);
    end
    check_drained("timeout");
  endtask

  task automatic test_boundary64();
    int t0;
    t0 = tmo_count;
    for (int i = 0; i < 5; i++) drive_period(TMO / 2, TMO / 2);
    check_drained("boundary64");
    n_vec = n_vec + 1;
    if (ratio_out !== 32'(TMO) || locked !== 1'b1 || tmo_count != t0) begin
      n_err = n_err + 1;
      $display("FAIL boundary64: ratio=%0d locked=%0b timeouts=%0d, expected %0d 1 0",
               ratio_out, locked, tmo_count - t0, TMO);
    end
  endtask

  task automatic test_reset_mid();
    int mv0;
    for (int i = 0; i < 3; i++) drive_period(5, 5);
    #2 reset = 1'b0;
    #1;
    n_vec = n_vec + 1;
    if ({ratio_out, high_out, meas_valid, locked, timeout} !== '0) begin
      n_err = n_err + 1;
      $display("FAIL reset_mid: ratio=%0d high=%0d mv=%0b lk=%0b to=%0b, expected all 0",
               ratio_out, high_out, meas_valid, locked, timeout);
    end
    exp_q.delete();
    m_armed = 1'b0;
    m_match = 0;
    mv0 = mv_count;
    repeat (3) @(posedge clk_in);
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) drive_period(5, 5);
    hold_low(3);
    check_drained("reset_mid");
    n_vec = n_vec + 1;
    if (mv_count - mv0 != 3) begin
      n_err = n_err + 1;
      $display("FAIL reset_rearm: %0d meas_valid after 4 rises, expected 3", mv_count - mv0);
    end
  endtask

  initial begin
    test_reset();
    test_ratio4();
    test_ratio_switch();
    test_toggle();
    test_timeout();
    test_boundary64();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
